// File: rtl/pipe_fetch_decode_if.sv
// Bundle between the fetch/decode block and its environment:
// program-load port, start control, issue fields and status.
interface pipe_fetch_decode_if #(
    parameter int ADR = 8,
    parameter int M   = 3,
    parameter int FUN = 3,
    parameter int IW  = 21
);
    logic           load_en;
    logic [ADR-1:0] load_addr;
    logic [IW-1:0]  load_data;
    logic           start;

    logic [M-1:0]   rs1;
    logic [M-1:0]   rs2;
    logic [M-1:0]   rd;
    logic [FUN-1:0] f;
    logic [ADR-1:0] addr;
    logic           issue_valid;
    logic [ADR-1:0] pc;
    logic           busy;
    logic           halted;

    modport master (
        output load_en, load_addr, load_data, start,
        input  rs1, rs2, rd, f, addr, issue_valid, pc, busy, halted
    );

    modport slave (
        input  load_en, load_addr, load_data, start,
        output rs1, rs2, rd, f, addr, issue_valid, pc, busy, halted
    );
endinterface

// File: rtl/pipe_fetch_decode.sv
// Fetch/decode stage: asynchronous-read instruction store, one-cycle issue
// register, and a two-slot rd history that inserts bubbles on RAW hazards.
//
// state | meaning
// IDLE  | after reset; program may be loaded, waits for start
// RUN   | fetching at pc and issuing (or bubbling) every cycle
// HALT  | halt word reached; pc parked on it, program may be reloaded
module pipe_fetch_decode #(
    parameter int ADR = 8,
    parameter int M   = 3,
    parameter int FUN = 3,
    parameter int IW  = 21
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_fetch_decode_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [ADR-1:0] PC_ONE = {{(ADR-1){1'b0}}, 1'b1};

    state_t         state, state_nxt;
    logic [IW-1:0]  mem [2**ADR];
    logic [ADR-1:0] pc, pc_nxt;

    logic [M-1:0]   rs1_q, rs2_q, rd_q, rs1_d, rs2_d, rd_d;
    logic [FUN-1:0] f_q, f_d;
    logic [ADR-1:0] addr_q, addr_d;
    logic           valid_q, valid_d;

    // Entry 0 is the most recent issue slot, entry 1 the one before it.
    logic [1:0]        hv_q, hv_d;
    logic [1:0][M-1:0] hrd_q, hrd_d;

    logic [IW-1:0]  word;
    logic           w_halt;
    logic [FUN-1:0] w_f;
    logic [M-1:0]   w_rd, w_rs1, w_rs2;
    logic [ADR-1:0] w_addr;
    logic           hazard;

    assign word   = mem[pc];
    assign w_halt = word[IW-1];
    assign w_f    = word[IW-2 -: FUN];
    assign w_rd   = word[IW-2-FUN -: M];
    assign w_rs1  = word[IW-2-FUN-M -: M];
    assign w_rs2  = word[IW-2-FUN-2*M -: M];
    assign w_addr = word[ADR-1:0];

    assign hazard = (hv_q[0] && (hrd_q[0] == w_rs1 || hrd_q[0] == w_rs2)) ||
                    (hv_q[1] && (hrd_q[1] == w_rs1 || hrd_q[1] == w_rs2));

    // Program store is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (bus.load_en && state != RUN)
            mem[bus.load_addr] <= bus.load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            f_q     <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            hv_q    <= '0;
            hrd_q   <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            f_q     <= f_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            hv_q    <= hv_d;
            hrd_q   <= hrd_d;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        rs1_d     = '0;
        rs2_d     = '0;
        rd_d      = '0;
        f_d       = '0;
        addr_d    = '0;
        valid_d   = 1'b0;
        hv_d      = hv_q;
        hrd_d     = hrd_q;
        case (state)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                    hv_d      = '0;
                end
            end
            RUN: begin
                if (w_halt) begin
                    state_nxt = HALT;
                    hv_d      = '0;
                end else if (hazard) begin
                    hv_d     = {hv_q[0], 1'b0};
                    hrd_d[1] = hrd_q[0];
                    hrd_d[0] = '0;
                end else begin
                    rs1_d    = w_rs1;
                    rs2_d    = w_rs2;
                    rd_d     = w_rd;
                    f_d      = w_f;
                    addr_d   = w_addr;
                    valid_d  = 1'b1;
                    pc_nxt   = pc + PC_ONE;
                    hv_d     = {hv_q[0], 1'b1};
                    hrd_d[1] = hrd_q[0];
                    hrd_d[0] = w_rd;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.rs1         = rs1_q;
    assign bus.rs2         = rs2_q;
    assign bus.rd          = rd_q;
    assign bus.f           = f_q;
    assign bus.addr        = addr_q;
    assign bus.issue_valid = valid_q;
    assign bus.pc          = pc;
    assign bus.busy        = (state == RUN);
    assign bus.halted      = (state == HALT);
endmodule

// File: doc/pipe_fetch_decode.md
PIPE_FETCH_DECODE -- requirements
Module: pipe_fetch_decode

Interface
REQ-001 Parameter ADR, default 8, meaning PC, instruction-memory and data-address width.
REQ-002 Parameter M, default 3, meaning register-specifier width.
REQ-003 Parameter FUN, default 3, meaning ALU function-code width.
REQ-004 Parameter IW, default 21, meaning instruction width: [20]=halt, [19:17]=f, [16:14]=rd, [13:11]=rs1, [10:8]=rs2, [7:0]=addr.
REQ-005 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 load_en  input  1  instruction-memory write strobe.
REQ-008 load_addr  input  ADR  instruction-memory write address.
REQ-009 load_data  input  IW  instruction word to store.
REQ-010 start  input  1  begin execution from PC 0.
REQ-011 rs1, rs2, rd  output  M each  register specifiers to the execute pipeline.
REQ-012 f  output  FUN  ALU function code.
REQ-013 addr  output  ADR  data-memory store address.
REQ-014 issue_valid  output  1  the outputs hold a real instruction this cycle.
REQ-015 pc  output  ADR  current program counter.
REQ-016 busy  output  1  high in RUN state.
REQ-017 halted  output  1  high in HALT state.

Function
REQ-018 Internal 2^ADR x IW instruction memory SHALL be read asynchronously at pc; contents SHALL NOT be reset.
REQ-019 load_en SHALL write load_data to load_addr only in IDLE or HALT; in RUN it SHALL be ignored.
REQ-020 FSM states SHALL be IDLE, RUN and HALT.
REQ-021 IDLE/HALT -> RUN on start; pc SHALL load 0 on that edge, with no issue that cycle.
REQ-022 In RUN, when the fetched word has halt=1: next state HALT, issue_valid 0, pc held at the halt address.
REQ-023 In RUN, with no halt and no hazard, outputs SHALL register the fetched fields, issue_valid SHALL be 1, and pc SHALL increment by 1. Issue latency is 1 cycle from pc to outputs.
REQ-024 pc SHALL wrap from 2^ADR-1 to 0 without stopping.
REQ-025 The block SHALL keep a 2-entry history of {valid, rd} for the last two issue slots; each edge in RUN SHALL shift in the current slot, with a bubble or halt shifting in valid=0.
REQ-026 Hazard condition: a valid history entry whose rd equals the fetched rs1 or rs2.
REQ-027 On a hazard, the block SHALL issue a bubble and hold pc.
REQ-028 Because bubbles enter history as invalid, no stall SHALL exceed 2 consecutive cycles.
REQ-029 Bubble, halt and non-RUN cycles SHALL drive rs1=rs2=rd=0, f=0, addr=0 and issue_valid=0.
REQ-030 start while in RUN SHALL be ignored.
REQ-031 In HALT, start SHALL restart from pc 0.
REQ-032 On the RUN -> HALT and HALT -> RUN transitions, the history SHALL be cleared.
REQ-033 busy SHALL equal (state==RUN).
REQ-034 halted SHALL equal (state==HALT).

Reset
REQ-035 rst_n low SHALL immediately force state IDLE, pc=0, history invalid, all instruction outputs 0, issue_valid=0, busy=0 and halted=0.
REQ-036 rst_n asserted mid-RUN SHALL abort without completing the in-flight issue.
REQ-037 After reset, the block SHALL stay in IDLE until start.

Verification
REQ-038 Load [0]: f=000 rd=1 rs1=2 rs2=3, [1]: f=001 rd=4 rs1=5 rs2=6 addr=8'h10, [2]: halt. Pulse start -> issues on 2 consecutive cycles with issue_valid=1, then halted=1 and pc=2.
REQ-039 [0]: rd=1, [1]: rs1=1 -> 2 bubble cycles with pc held at 1, then [1] issues.
REQ-040 [0]: rd=1, [1]: unrelated, [2]: rs2=1 -> exactly 1 bubble before [2] issues.
REQ-041 Memory all non-halt and independent, with start -> pc goes 255 -> 0 with continuous issue_valid=1.
REQ-042 Drop rst_n during RUN at pc=5 -> outputs 0 and state IDLE at once; load_en writes during RUN SHALL not alter instructions fetched afterward.
REQ-043 In HALT, pulse start -> pc=0, the program re-executes, and no stale hazard stall occurs on the first issue.
